// File: rtl/bist_pattern_sender.sv
// BIST pattern sender: streams TEST_CASES test patterns (PRBS, walking-one,
// checkerboard or all-ones/all-zeros) onto the channel bus, then bypasses
// functional traffic once the run is complete.
module bist_pattern_sender #(
  parameter int unsigned TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int unsigned TEST_CASES    = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic                     stall,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic [TEST_CHANNELS-1:0] output_channels,
  output logic                     pattern_valid,
  output logic                     busy,
  output logic                     ready,
  output logic [31:0]              patterns_sent
);

  localparam int unsigned TW = TEST_CHANNELS;
  localparam int unsigned IW = (TEST_CHANNELS > 1) ? $clog2(TEST_CHANNELS) : 1;
  localparam int unsigned CW = 32;
  localparam logic [31:0]   LFSR_TAPS = 32'h80200003;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TEST_CASES);
  localparam logic [IW-1:0] IDX_LAST = IW'(TEST_CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {PAT_PRBS, PAT_WALK, PAT_CHECKER, PAT_ALT} pat_t;

  // Even-bit mask (...0101) used by the checkerboard pattern.
  function automatic logic [TW-1:0] even_bits();
    logic [TW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(TW); i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [TW-1:0] EVEN_MASK = even_bits();

  state_t        state_q, state_d;
  pat_t          mode_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] test_q;
  logic [31:0]   lfsr_q;
  logic [IW-1:0] idx_q;

  logic          start_go;
  logic          advance;
  logic [TW-1:0] next_pat;
  logic [31:0]   lfsr_next;
  logic [IW-1:0] idx_next;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort dominates, start only honoured outside RUN.
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    advance  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_RUN;
            start_go = 1'b1;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (count_q == LAST_COUNT) state_d = S_DONE;
            else                       advance = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next pattern for the latched mode; phase comes from the count parity.
  always_comb begin
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    idx_next  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    next_pat  = '0;
    case (mode_q)
      PAT_PRBS:    next_pat = TW'({test_q, lfsr_q});
      PAT_WALK:    next_pat = TW'(1) << idx_q;
      PAT_CHECKER: next_pat = count_q[0] ? ~EVEN_MASK : EVEN_MASK;
      PAT_ALT:     next_pat = count_q[0] ? '0 : '1;
      default:     next_pat = '0;
    endcase
  end

  // Pattern datapath: count, shift register, LFSR and walking index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      test_q  <= '0;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      mode_q  <= PAT_PRBS;
    end else if (abort) begin
      count_q <= '0;
      test_q  <= '0;
    end else if (start_go) begin
      count_q <= '0;
      test_q  <= '0;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      mode_q  <= pat_t'(mode);
    end else if (advance) begin
      count_q <= count_q + CW'(1);
      test_q  <= next_pat;
      if (mode_q == PAT_PRBS) lfsr_q <= lfsr_next;
      if (mode_q == PAT_WALK) idx_q  <= idx_next;
    end
  end

  // Output mux: zeros when idle, pattern while running, bypass when done.
  always_comb begin
    output_channels = '0;
    case (state_q)
      S_RUN:   output_channels = test_q;
      S_DONE:  output_channels = input_channels;
      default: output_channels = '0;
    endcase
  end

  assign pattern_valid = (state_q == S_RUN) && (count_q != '0);
  assign busy          = (state_q == S_RUN);
  assign ready         = (state_q == S_DONE);
  assign patterns_sent = count_q;

endmodule

// File: doc/bist_pattern_sender.md
BIST_PATTERN_SENDER -- requirements
Module: bist_pattern_sender

Interface
REQ-001 Parameter TEST_CHANNELS, default 70: width of the test and bypass channel buses, legal range 1..1024.
REQ-002 Parameter SEED, default 32'hdeadbeef: PRBS start state; must be nonzero.
REQ-003 Parameter TEST_CASES, default 1000: patterns emitted per run, legal range 1..2^32-1.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous active-high reset.
REQ-007 Port start, input, 1: single-cycle request to begin a run.
REQ-008 Port abort, input, 1: terminates any activity and returns the block to IDLE.
REQ-009 Port mode, input, 2: pattern select; 0 PRBS, 1 walking-one, 2 checkerboard, 3 all-ones/all-zeros alternate.
REQ-010 Port stall, input, 1: consumer back-pressure; freezes pattern advance.
REQ-011 Port input_channels, input, TEST_CHANNELS: functional traffic, bypassed once the run is complete.
REQ-012 Port output_channels, output, TEST_CHANNELS: test pattern or bypassed traffic.
REQ-013 Port pattern_valid, output, 1: output_channels holds a test pattern.
REQ-014 Port busy, output, 1: high in RUN.
REQ-015 Port ready, output, 1: high in DONE.
REQ-016 Port patterns_sent, output, 32: number of patterns loaded in the current or last run.

Function
REQ-017 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in registers.
REQ-018 IDLE or DONE, start=1, abort=0 -> RUN; on that edge: count<=0, test_output<=0, LFSR<=SEED, mode latched, walking/phase index<=0.
REQ-019 start SHALL be ignored while in RUN; changes on mode SHALL be ignored outside the start edge.
REQ-020 RUN, stall=0, count<TEST_CASES ("advance"): test_output<=next pattern; count<=count+1.
REQ-021 RUN, stall=0, count==TEST_CASES -> DONE; RUN with stall=1 -> hold all state.
REQ-022 abort=1 in any state -> IDLE on the next edge, with count and test_output cleared; abort wins over start.
REQ-023 PRBS: word=current LFSR state; next test_output = ((test_output<<32) | word) truncated to TEST_CHANNELS bits; LFSR then steps.
REQ-024 The LFSR SHALL be a 32-bit Galois type: lsb=1 -> (s>>1)^32'h80200003, else s>>1; it steps only on PRBS advances.
REQ-025 Walking-one: pattern k (1-based) has only bit (k-1) mod TEST_CHANNELS set; the index wraps TEST_CHANNELS-1 -> 0.
REQ-026 Checkerboard: odd k sets even bits (...0101); even k sets odd bits (...1010).
REQ-027 Mode 3: odd k = all ones; even k = all zeros.
REQ-028 output_channels SHALL be 0 in IDLE, test_output in RUN and input_channels (combinational bypass) in DONE.
REQ-029 pattern_valid SHALL equal (state==RUN && count!=0); patterns_sent SHALL equal count, held in DONE and cleared by start or abort.
REQ-030 Latency: with start at edge 0 and stall never asserted, pattern k is visible cycles k..k (one cycle each) after edge k, and ready rises after edge TEST_CASES+1.
REQ-031 The count SHALL never exceed TEST_CASES and SHALL not wrap.

Reset
REQ-032 On reset: state=IDLE, count=0, test_output=0, LFSR=SEED, index=0.
REQ-033 Output values during and after reset: output_channels=0, pattern_valid=0, busy=0, ready=0, patterns_sent=0.
REQ-034 Reset asserted mid-run SHALL abandon the run; a new start is required after release.

Verification
REQ-035 Walking-one: TEST_CHANNELS=8, TEST_CASES=4, mode=1, start pulse -> output_channels 0x01,0x02,0x04,0x08 with pattern_valid=1; then ready=1, patterns_sent=4, output_channels follows input_channels.
REQ-036 PRBS: defaults, mode=0 -> pattern1=0xdeadbeef (upper bits 0); pattern2=0xdeadbeef_ef76df74.
REQ-037 Stall: TEST_CHANNELS=8, TEST_CASES=4, mode=1, stall=1 for 3 cycles after pattern 2 -> 0x02 held 4 cycles, then 0x04, 0x08; sequence otherwise unchanged.
REQ-038 Wrap and modes: TEST_CHANNELS=3, TEST_CASES=5, mode=1 -> 1,2,4,1,2; mode=2 -> 5,2,5,2,5; mode=3 -> 7,0,7,0,7.
REQ-039 Abort and reset: abort after pattern 2 -> IDLE, output 0, patterns_sent=0; start+abort together -> stay in IDLE; reset mid-run -> all outputs 0; a restart from DONE repeats an identical sequence.
